// File: rtl/seg_sched.sv
// Display scheduler for an 8-digit seven-segment board driven through a
// 74HC595 chain. It picks one of NCLI clients by key press or timed
// auto-rotation, captures that client's 32-bit value at frame boundaries,
// and serializes it digit by digit as {select, segment} words.
module seg_sched #(
  parameter int NCLI = 4,
  parameter int DIV  = 4,
  parameter int HOLD = 1000000,
  localparam int SW  = $clog2(NCLI)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCLI-1:0]    req_i,
  input  logic [NCLI*32-1:0] data_i,
  output logic [NCLI-1:0]    ack_o,
  input  logic               key_next_i,
  input  logic               auto_en_i,
  output logic [SW-1:0]      sel_o,
  output logic               busy_o,
  output logic               ds_o,
  output logic               shclk_o,
  output logic               stclk_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_e;

  state_e            state_q, state_d;
  logic [1:0]        key_sync_q;
  logic              key_prev_q;
  logic [SW-1:0]     sel_q, sel_d;
  logic [HW-1:0]     dwell_q, dwell_d;
  logic [31:0]       fb_q, fb_d;
  logic [NCLI-1:0]   ack_q, ack_d;
  logic [2:0]        idx_q, idx_d;
  logic [15:0]       word_q, word_d;
  logic [3:0]        bit_q, bit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ds_q, ds_d;
  logic              shclk_q, shclk_d;
  logic              stclk_q, stclk_d;

  logic              key_edge, dwell_done, step, cnt_last;

  // Active-low segment pattern for one hex nibble.
  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = 8'h03;  4'h1: seg_lut = 8'h9f;
      4'h2: seg_lut = 8'h25;  4'h3: seg_lut = 8'h0d;
      4'h4: seg_lut = 8'h99;  4'h5: seg_lut = 8'h49;
      4'h6: seg_lut = 8'h41;  4'h7: seg_lut = 8'h1f;
      4'h8: seg_lut = 8'h01;  4'h9: seg_lut = 8'h09;
      4'ha: seg_lut = 8'h11;  4'hb: seg_lut = 8'hc1;
      4'hc: seg_lut = 8'h63;  4'hd: seg_lut = 8'h85;
      4'he: seg_lut = 8'h61;  default: seg_lut = 8'h71;
    endcase
  endfunction

  assign key_edge   = key_sync_q[1] & ~key_prev_q;
  assign dwell_done = auto_en_i && (dwell_q == HW'(HOLD - 1));
  // A key edge and a dwell expiry in the same cycle collapse into one step.
  assign step       = key_edge | dwell_done;
  assign cnt_last   = (cnt_q == CW'(DIV - 1));

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one IDLE and one LOAD cycle per digit, then shift and latch.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_last && shclk_q && (bit_q == 4'd0)) state_d = LATCH;
      LATCH:   if (cnt_last && !stclk_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: selection, capture, word build and serial timing.
  always_comb begin
    sel_d   = sel_q;
    dwell_d = dwell_q;
    fb_d    = fb_q;
    ack_d   = '0;
    idx_d   = idx_q;
    word_d  = word_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    ds_d    = ds_q;
    shclk_d = shclk_q;
    stclk_d = stclk_q;

    if (step) begin
      sel_d   = (sel_q == SW'(NCLI - 1)) ? '0 : sel_q + 1'b1;
      dwell_d = '0;
    end else if (auto_en_i) begin
      dwell_d = dwell_q + 1'b1;
    end else begin
      dwell_d = '0;
    end

    case (state_q)
      IDLE: begin
        // Capture uses the current (pre-step) selection.
        if ((idx_q == 3'd0) && req_i[sel_q]) begin
          fb_d         = data_i[{sel_q, 5'd0} +: 32];
          ack_d[sel_q] = 1'b1;
        end
      end
      LOAD: begin
        word_d  = {8'h80 >> idx_q, seg_lut(fb_q[{idx_q, 2'b00} +: 4])};
        ds_d    = word_d[15];
        bit_d   = 4'd15;
        cnt_d   = '0;
        shclk_d = 1'b0;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (!shclk_q) begin
            shclk_d = 1'b1;
          end else begin
            shclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              stclk_d = 1'b1;
            end else begin
              // New data bit only appears as the low phase begins.
              bit_d = bit_q - 4'd1;
              ds_d  = word_q[bit_q - 4'd1];
            end
          end
        end
      end
      LATCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (stclk_q) stclk_d = 1'b0;
          else         idx_d   = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared asynchronously so a reset never latches a partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_q <= '0;
      key_prev_q <= 1'b0;
      sel_q      <= '0;
      dwell_q    <= '0;
      fb_q       <= '0;
      ack_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      ds_q       <= 1'b0;
      shclk_q    <= 1'b0;
      stclk_q    <= 1'b0;
    end else begin
      key_sync_q <= {key_sync_q[0], key_next_i};
      key_prev_q <= key_sync_q[1];
      sel_q      <= sel_d;
      dwell_q    <= dwell_d;
      fb_q       <= fb_d;
      ack_q      <= ack_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      ds_q       <= ds_d;
      shclk_q    <= shclk_d;
      stclk_q    <= stclk_d;
    end
  end

  assign sel_o   = sel_q;
  assign ack_o   = ack_q;
  assign busy_o  = (state_q != IDLE);
  assign ds_o    = ds_q;
  assign shclk_o = shclk_q;
  assign stclk_o = stclk_q;

endmodule

// File: tb/tb_seg_sched.sv
// Self-checking bench for seg_sched: a monitor rebuilds each shifted word
// and compares it against a queue of expected words; directed steps cover
// capture, key stepping, auto-rotation and reset mid-shift.
module tb_seg_sched;

  localparam int NCLI = 4;
  localparam int DIV  = 4;
  localparam int HOLD = 50;
  localparam int DIGIT_CYC = 2 + 34 * DIV;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NCLI-1:0]     req = '0;
  logic [NCLI*32-1:0]  data = '0;
  logic [NCLI-1:0]     ack;
  logic                key = 1'b0;
  logic                auto_en = 1'b0;
  logic [1:0]          sel;
  logic                busy, ds, shclk, stclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  seg_tab [16] = '{8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
                                 8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Monitor state
  logic [15:0] shreg = '0;
  int  bitcnt = 0;
  int  st_count = 0;
  int  last_st_cyc = 0;
  bit  st_valid = 0;
  int  sh_hi = 0;
  int  st_hi = 0;
  logic prev_sh = 1'b0;
  logic prev_st = 1'b0;
  int  ack_cnt [NCLI] = '{0, 0, 0, 0};

  seg_sched #(.NCLI(NCLI), .DIV(DIV), .HOLD(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .data_i     (data),
    .ack_o      (ack),
    .key_next_i (key),
    .auto_en_i  (auto_en),
    .sel_o      (sel),
    .busy_o     (busy),
    .ds_o       (ds),
    .shclk_o    (shclk),
    .stclk_o    (stclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [31:0] v, input int k);
    logic [7:0] sb;
    sb = 8'h80 >> k;
    return {sb, seg_tab[v[4*k +: 4]]};
  endfunction

  task automatic push_frame(input logic [31:0] v);
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_word(v, k));
  endtask

  task automatic wait_latches(input int n);
    int target;
    int budget;
    target = st_count + n;
    budget = n * DIGIT_CYC + 200;
    while (st_count < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("latches_seen", {31'b0, st_count >= target}, 32'd1);
  endtask

  task automatic press();
    @(negedge clk); key = 1'b1;
    repeat (4) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic wait_sel(output int t);
    logic [1:0] s0;
    int b;
    s0 = sel;
    b = 0;
    t = -1;
    while (t < 0 && b < 200) begin
      @(negedge clk); #1;
      b++;
      if (sel !== s0) t = cyc;
    end
    check("sel_step_seen", {31'b0, sel !== s0}, 32'd1);
  endtask

  // Monitor: rebuild words on shclk rises, score them on stclk rises.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bitcnt   = 0;
        st_valid = 0;
        sh_hi    = 0;
        st_hi    = 0;
        prev_sh  = 1'b0;
        prev_st  = 1'b0;
      end else begin
        for (int k = 0; k < NCLI; k++) if (ack[k]) ack_cnt[k]++;
        if (shclk && !prev_sh) begin
          shreg = {shreg[14:0], ds};
          bitcnt++;
        end
        if (shclk) sh_hi++;
        else if (prev_sh) begin
          check("shclk_high_width", sh_hi, DIV);
          sh_hi = 0;
        end
        if (stclk && !prev_st) begin
          check("bits_before_latch", bitcnt, 16);
          bitcnt = 0;
          st_count++;
          if (st_valid) check("digit_period", cyc - last_st_cyc, DIGIT_CYC);
          last_st_cyc = cyc;
          st_valid = 1;
          if (exp_q.size() > 0) begin
            logic [15:0] w;
            w = exp_q.pop_front();
            check("latched_word", {16'b0, shreg}, {16'b0, w});
          end
        end
        if (stclk) st_hi++;
        else if (prev_st) begin
          check("stclk_high_width", st_hi, DIV);
          st_hi = 0;
        end
        prev_sh = shclk;
        prev_st = stclk;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_sel;
    int t, t_prev;
    logic [15:0] w;

    // 1. Reset values, then first frame with fb=0.
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sel", {30'b0, sel}, 0);
    check("rst_ack", {28'b0, ack}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_ds", {31'b0, ds}, 0);
    check("rst_shclk", {31'b0, shclk}, 0);
    check("rst_stclk", {31'b0, stclk}, 0);
    exp_sel = 0;
    push_frame(32'h0);
    @(negedge clk); rst_n = 1'b1;
    wait_latches(8);

    // 2. Client 0 requests; captured at the next frame boundary.
    data[31:0] = 32'h1234ABCD;
    req = 4'b0001;
    push_frame(32'h1234ABCD);
    wait_latches(8);
    check("ack0_once", ack_cnt[0], 1);
    check("ack1_none", ack_cnt[1], 0);
    req = 4'b0000;
    push_frame(32'h1234ABCD);
    wait_latches(8);
    check("ack0_no_req", ack_cnt[0], 1);

    // 3. Unselected client requests are ignored until selected.
    data[95:64] = 32'hDEADBEEF;
    req = 4'b0100;
    push_frame(32'h1234ABCD);
    push_frame(32'h1234ABCD);
    push_frame(32'h1234ABCD);
    wait_latches(16);
    check("ack2_ignored", ack_cnt[2], 0);
    repeat (20) @(negedge clk);
    press(); exp_sel = 1;
    press(); exp_sel = 2;
    check("sel_after_two", {30'b0, sel}, exp_sel);
    push_frame(32'hDEADBEEF);
    wait_latches(8);
    check("ack2_not_yet", ack_cnt[2], 0);
    wait_latches(8);
    check("ack2_captured", ack_cnt[2], 1);
    check("ack0_unchanged", ack_cnt[0], 1);
    check("ack3_none", ack_cnt[3], 0);
    req = 4'b0000;

    // 4. Key stepping, wrap, and a held key giving one step.
    press(); exp_sel = 3;
    check("sel_3", {30'b0, sel}, exp_sel);
    press(); exp_sel = 0;
    check("sel_wrap", {30'b0, sel}, exp_sel);
    @(negedge clk); key = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    exp_sel = 1;
    check("sel_held_key", {30'b0, sel}, exp_sel);
    key = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("sel_after_release", {30'b0, sel}, exp_sel);
    press(); exp_sel = 2;
    check("sel_press_2", {30'b0, sel}, exp_sel);
    press(); exp_sel = 3;
    check("sel_press_3", {30'b0, sel}, exp_sel);
    press(); exp_sel = 0;
    check("sel_press_0", {30'b0, sel}, exp_sel);

    // 5. Auto-rotation every HOLD cycles; a key edge restarts the dwell.
    @(negedge clk); auto_en = 1'b1; t_prev = cyc;
    wait_sel(t); exp_sel = (exp_sel + 1) % NCLI;
    check("auto_first_dwell", t - t_prev, HOLD);
    check("auto_sel_a", {30'b0, sel}, exp_sel);
    t_prev = t;
    wait_sel(t); exp_sel = (exp_sel + 1) % NCLI;
    check("auto_second_dwell", t - t_prev, HOLD);
    check("auto_sel_b", {30'b0, sel}, exp_sel);
    t_prev = t;
    while (cyc < t_prev + 27) @(negedge clk);
    key = 1'b1;
    wait_sel(t); exp_sel = (exp_sel + 1) % NCLI;
    check("key_step_time", t - t_prev, 30);
    check("key_step_sel", {30'b0, sel}, exp_sel);
    t_prev = t;
    repeat (2) @(negedge clk);
    key = 1'b0;
    wait_sel(t); exp_sel = (exp_sel + 1) % NCLI;
    check("dwell_restart", t - t_prev, HOLD);
    check("auto_sel_c", {30'b0, sel}, exp_sel);
    @(negedge clk); auto_en = 1'b0;
    repeat (120) @(negedge clk);
    #1;
    check("auto_off_hold", {30'b0, sel}, exp_sel);

    // 6. Reset during the bit-7 high phase of digit 3.
    t = 0;
    while (!((st_count % 8 == 3) && bitcnt == 9 && shclk) && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check("mid_shift_reached", {31'b0, shclk}, 32'd1);
    w = exp_word(32'hDEADBEEF, 3);
    check("ds_bit7", {31'b0, ds}, {31'b0, w[7]});
    check("queue_empty_pre_rst", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ds", {31'b0, ds}, 0);
    check("mid_rst_shclk", {31'b0, shclk}, 0);
    check("mid_rst_stclk", {31'b0, stclk}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_sel", {30'b0, sel}, 0);
    exp_sel = 0;
    push_frame(32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_latches(8);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
